// File: rtl/cla_mp_adder_pkg.sv
// Shared definitions for the multi-precision CLA adder: sizing defaults,
// controller states and the 4-bit lookahead helpers used by the slice adder.
package cla_mp_adder_pkg;

    localparam int W_DEF     = 128;
    localparam int BEATS_DEF = 4;
    localparam int N_DEF     = W_DEF * BEATS_DEF;
    localparam int KW_DEF    = $clog2(BEATS_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Carries into each of four lookahead elements, element 0 receives ci.
    function automatic logic [3:0] la_carries(input logic [3:0] g,
                                              input logic [3:0] p,
                                              input logic       ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    function automatic logic group_g(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    function automatic logic group_p(input logic [3:0] p);
        return &p;
    endfunction

endpackage

// File: rtl/cla_mp_adder_cla128bits.sv
// 128-bit carry-lookahead adder built as a three-level tree of 4-way
// lookahead units (4-bit blocks, 16-bit groups, 64-bit sections).
module cla128bits
    import cla_mp_adder_pkg::*;
(
    input  logic         cin,
    input  logic [127:0] a,
    input  logic [127:0] b,
    output logic [127:0] s,
    output logic         cout,
    output logic         gen,
    output logic         prop
);

    logic [127:0] g;
    logic [127:0] p;
    logic [127:0] c;
    logic [31:0]  g1;
    logic [31:0]  p1;
    logic [31:0]  c1;
    logic [7:0]   g2;
    logic [7:0]   p2;
    logic [7:0]   c2;
    logic [1:0]   g3;
    logic [1:0]   p3;
    logic [1:0]   c3;

    assign g = a & b;
    assign p = a ^ b;

    // Upward sweep: generate/propagate summaries per level.
    for (genvar gi = 0; gi < 32; gi++) begin : g_lvl1
        assign g1[gi] = group_g(g[gi*4 +: 4], p[gi*4 +: 4]);
        assign p1[gi] = group_p(p[gi*4 +: 4]);
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_lvl2
        assign g2[gi] = group_g(g1[gi*4 +: 4], p1[gi*4 +: 4]);
        assign p2[gi] = group_p(p1[gi*4 +: 4]);
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_lvl3
        assign g3[gi] = group_g(g2[gi*4 +: 4], p2[gi*4 +: 4]);
        assign p3[gi] = group_p(p2[gi*4 +: 4]);
    end

    assign gen  = g3[1] | (p3[1] & g3[0]);
    assign prop = p3[1] & p3[0];
    assign cout = gen | (prop & cin);

    // Downward sweep: distribute carries back to every bit.
    assign c3[0] = cin;
    assign c3[1] = g3[0] | (p3[0] & cin);

    for (genvar gi = 0; gi < 2; gi++) begin : g_c2
        assign c2[gi*4 +: 4] = la_carries(g2[gi*4 +: 4], p2[gi*4 +: 4], c3[gi]);
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_c1
        assign c1[gi*4 +: 4] = la_carries(g1[gi*4 +: 4], p1[gi*4 +: 4], c2[gi]);
    end

    for (genvar gi = 0; gi < 32; gi++) begin : g_c0
        assign c[gi*4 +: 4] = la_carries(g[gi*4 +: 4], p[gi*4 +: 4], c1[gi]);
    end

    assign s = p ^ c;

endmodule

// File: rtl/cla_mp_adder.sv
// Multi-precision add/subtract: one 128-bit CLA slice is reused for BEATS
// cycles, carrying between slices through a register.
module cla_mp_adder
    import cla_mp_adder_pkg::*;
#(
    parameter  int W     = W_DEF,
    parameter  int BEATS = BEATS_DEF,
    localparam int N     = W * BEATS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sub,
    input  logic         cin,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t         state_reg;
    state_t         state_next;
    logic [KW-1:0]  k_reg;
    logic           carry_reg;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic [N-1:0]   s_reg;
    logic           cout_reg;
    logic           ovf_reg;

    logic [W-1:0]   a_slices [BEATS];
    logic [W-1:0]   b_slices [BEATS];
    logic [W-1:0]   a_slice;
    logic [W-1:0]   b_slice;
    logic [W-1:0]   slice_sum;
    logic           slice_cout;
    logic           slice_gen_unused;
    logic           slice_prop_unused;
    logic           last_beat;

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
        assign a_slices[gi] = a_reg[gi*W +: W];
        assign b_slices[gi] = b_reg[gi*W +: W];
    end

    assign a_slice   = a_slices[k_reg];
    assign b_slice   = b_slices[k_reg];
    assign last_beat = (k_reg == KW'(BEATS - 1));

    cla128bits u_cla (
        .cin  (carry_reg),
        .a    (a_slice),
        .b    (b_slice),
        .s    (slice_sum),
        .cout (slice_cout),
        .gen  (slice_gen_unused),
        .prop (slice_prop_unused)
    );

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_beat) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1, so B is inverted once here.
                        a_reg     <= a;
                        b_reg     <= b ^ {N{sub}};
                        carry_reg <= sub ? 1'b1 : cin;
                        k_reg     <= '0;
                    end
                end
                RUN: begin
                    s_reg[k_reg*W +: W] <= slice_sum;
                    carry_reg           <= slice_cout;
                    k_reg               <= k_reg + 1'b1;
                    if (last_beat) begin
                        cout_reg <= slice_cout;
                        ovf_reg  <= (a_reg[N-1] == b_reg[N-1])
                                  & (slice_sum[W-1] != a_reg[N-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign s    = s_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_cla_mp_adder.sv
// Directed and random checks of cla_mp_adder against a 512-bit reference.
module tb_cla_mp_adder;

    localparam int N = 512;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [N+1:0] exp_q [$];

    cla_mp_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N+1:0] obs, input logic [N+1:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result packed as {cout, ovf, s}.
    function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic sb, input logic ci);
        logic [N:0] full;
        logic       v;
        if (sb) full = {1'b0, x} - {1'b0, y} + {1'b1, {N{1'b0}}};
        else    full = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
        if (sb) v = (x[N-1] != y[N-1]) && (full[N-1] != x[N-1]);
        else    v = (x[N-1] == y[N-1]) && (full[N-1] != x[N-1]);
        return {full[N], v, full[N-1:0]};
    endfunction

    function automatic logic [N-1:0] rand512();
        logic [N-1:0] r;
        for (int i = 0; i < N/32; i++) r[i*32 +: 32] = $urandom();
        case ($urandom_range(0, 7))
            0: r = '1;
            1: r = '0;
            2: r = {1'b1, {(N-1){1'b0}}};
            default: ;
        endcase
        return r;
    endfunction

    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic sb,
                        input logic ci, input bit push, input logic [N+1:0] e);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk1("send_timeout", in_ready, 1'b1);
        a = x;
        b = y;
        sub = sb;
        cin = ci;
        in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input bit rnd);
        int n = 0;
        bit hs = 0;
        logic [N+1:0] e;
        while (n < 200) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                hs = 1;
                break;
            end
            tick();
            n++;
        end
        if (!hs) begin
            chk1({tag, "_timeout"}, out_valid, 1'b1);
            out_ready = 1'b0;
            return;
        end
        e = exp_q.pop_front();
        chk(tag, {cout, ovf, s}, e);
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rs;
        logic         rc;
        logic [N+1:0] hold;
        int           n;

        // Reset
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", {cout, ovf, s}, '0);

        // All-ones plus one, with latency check
        send('1, {{(N-1){1'b0}}, 1'b1}, 1'b0, 1'b0, 1, {1'b1, 1'b0, {N{1'b0}}});
        chk1("run_in_ready", in_ready, 1'b0);
        tick();
        tick();
        tick();
        chk1("lat_before", out_valid, 1'b0);
        tick();
        chk1("lat_at", out_valid, 1'b1);
        collect("add_wrap", 0);
        chk1("post_hs_in_ready", in_ready, 1'b1);

        // Carry crossing three beat boundaries
        send({{128{1'b0}}, {384{1'b1}}}, '0, 1'b0, 1'b1, 1,
             {1'b0, 1'b0, {127{1'b0}}, 1'b1, {384{1'b0}}});
        collect("carry_chain", 0);

        // Subtraction wrap-around and signed overflow
        send(512'd5, 512'd7, 1'b1, 1'b1, 1, {1'b0, 1'b0, {(N-1){1'b1}}, 1'b0});
        collect("sub_wrap", 0);
        send({1'b1, {(N-1){1'b0}}}, 512'd1, 1'b1, 1'b0, 1, {1'b1, 1'b1, 1'b0, {(N-1){1'b1}}});
        collect("sub_ovf", 0);

        // Backpressure in DONE with inputs churning
        send(512'd100, 512'd23, 1'b0, 1'b1, 1, {2'b00, 512'd124});
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        hold = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            a = rand512();
            b = rand512();
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            tick();
            chk("bp_hold", {cout, ovf, s}, hold);
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_out_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        collect("bp_result", 0);
        chk1("bp_after_in_ready", in_ready, 1'b1);
        chk1("bp_after_out_valid", out_valid, 1'b0);

        // Reset at beat k=2 discards the operation
        send({256{2'b10}}, {256{2'b01}}, 1'b0, 1'b0, 0, '0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk1("abort_in_ready", in_ready, 1'b1);
        chk1("abort_out_valid", out_valid, 1'b0);
        chk("abort_result", {cout, ovf, s}, '0);
        for (int i = 0; i < 6; i++) tick();
        chk1("abort_no_valid", out_valid, 1'b0);
        send(512'd3, 512'd4, 1'b0, 1'b0, 1, {2'b00, 512'd7});
        collect("after_abort", 0);

        // Random back-to-back traffic against the reference model
        for (int i = 0; i < 1000; i++) begin
            ra = rand512();
            rb = rand512();
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            send(ra, rb, rs, rc, 1, model(ra, rb, rs, rc));
            collect($sformatf("rand_%0d", i), 1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cla_mp_adder.md
CLA_MP_ADDER -- requirements
Module: cla_mp_adder

Interface
REQ-001 The block SHALL have parameter W, default 128, meaning the slice width processed per beat; it is fixed at 128 to match cla128bits.
REQ-002 The block SHALL have parameter BEATS, default 4, meaning the number of slices per operand; operand width N = W*BEATS = 512.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock, rising edge active.
REQ-004 Port rst_n SHALL be an input, 1 bit: the reset, synchronous and active-low.
REQ-005 Port in_valid SHALL be an input, 1 bit: operands and mode are valid.
REQ-006 Port in_ready SHALL be an output, 1 bit: the block accepts operands.
REQ-007 Port sub SHALL be an input, 1 bit: 0 selects a+b+cin; 1 selects a-b.
REQ-008 Port cin SHALL be an input, 1 bit: carry-in for add mode, ignored when sub=1.
REQ-009 Port a SHALL be an input, N bits: operand A.
REQ-010 Port b SHALL be an input, N bits: operand B.
REQ-011 Port out_valid SHALL be an output, 1 bit: the result is valid.
REQ-012 Port out_ready SHALL be an input, 1 bit: the consumer accepts the result.
REQ-013 Port s SHALL be an output, N bits: the sum or difference.
REQ-014 Port cout SHALL be an output, 1 bit: the carry out of bit N-1 (in sub mode, 1 means no borrow).
REQ-015 Port ovf SHALL be an output, 1 bit: two's-complement signed overflow.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-018 On an input handshake (in_valid & in_ready), the block SHALL register a, b^{N{sub}} (effective B), the carry register <= (sub ? 1 : cin) and beat index k <= 0, and SHALL enter RUN.
REQ-019 In each RUN cycle, one cla128bits instance SHALL add slice k of A and effective B with the carry register; s[k*W +: W] <= slice sum; carry <= slice cout; k <= k+1.
REQ-020 When k = BEATS-1 in RUN, the block SHALL write the last slice, latch cout from that slice's carry, latch ovf = (A[N-1] == Beff[N-1]) & (sum[N-1] != A[N-1]), and enter DONE.
REQ-021 Latency: with the input handshake at edge T, out_valid SHALL first be 1 after edge T+BEATS (4 cycles); throughput SHALL be one operation per BEATS+1 cycles minimum.
REQ-022 In DONE, s, cout and ovf SHALL hold stable while out_valid=1 and out_ready=0, for an unbounded wait.
REQ-023 On an output handshake, the block SHALL enter IDLE, and in_ready SHALL be 1 on the next cycle; no bypass from DONE to RUN is allowed.
REQ-024 Input changes while in RUN or DONE SHALL have no effect.
REQ-025 Subtraction wrap-around: a-b with a<b SHALL give s = a-b mod 2^N and cout=0.
REQ-026 Carry SHALL propagate across all slice boundaries exactly once per beat, with no combinational path between beats.

Reset
REQ-027 With rst_n=0 at a rising clk edge, the block SHALL enter IDLE and clear k, carry, s, cout and ovf to 0, giving in_ready=1 and out_valid=0 in the next cycle.
REQ-028 Reset during RUN or DONE SHALL abort the operation; the partial result SHALL be discarded and no out_valid SHALL be produced.
REQ-029 Reset SHALL take priority over any simultaneous handshake.

Structure
REQ-030 A shared package SHALL hold the state enumeration (IDLE/RUN/DONE), the W/BEATS/N defaults and the beat-index width clog2(BEATS).
REQ-031 The block SHALL instantiate exactly one cla128bits as its sub-module, using its cin/a/b/s/cout ports; gen and prop SHALL be left unused.
REQ-032 All state SHALL be in one clocked process; slice selection SHALL be a k-indexed multiplexer.

Verification
REQ-033 Add scenario: a=2^512-1, b=1, cin=0, sub=0 -> s=0, cout=1, ovf=0, out_valid 4 cycles after accept.
REQ-034 Carry-chain scenario: a=0x..FFFF (low 384 bits all 1, upper 0), b=0, cin=1 -> s=2^384, cout=0, showing carry crossing three beat boundaries.
REQ-035 Subtract scenario: a=5, b=7, sub=1 -> s=2^512-2, cout=0, ovf=0; then a=2^511, b=1, sub=1 -> s=2^511-1, ovf=1.
REQ-036 Backpressure scenario: hold out_ready=0 for 10 cycles in DONE -> s/cout/ovf stable, in_ready=0 throughout, a and b toggled with no effect.
REQ-037 Reset scenario: assert rst_n=0 at beat k=2 -> next cycle in_ready=1, out_valid=0, s=0; a new add of 3+4 then returns s=7.
REQ-038 Random scenario: 1000 back-to-back random operations with random sub/cin/out_ready SHALL match a 512-bit reference model.
